pooling_average_readout: RTL and testbench

Read-back side of the average-pooling accumulator BRAM. After the accumulate pass has summed every IFM byte of a pooling window into one 32-bit BRAM word per channel, this block walks the accumulator addresses and scales each sum by a fixed-point reciprocal of the window size. It saturates each result to 8 bits and packs four channels per 32-bit output word, byte lane order matching the accumulator's `control_data` lane select. Each word is streamed to the next layer's IFM buffer over a valid/ready handshake.

---
 rtl/pooling_average_readout_if.sv | 22 ++
 rtl/pooling_average_readout.sv | 126 ++++++++++++
 tb/tb_pooling_average_readout.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_average_readout_if.sv
// Read port toward the accumulator BRAM and the packed-average output stream.
// The master side is the readout engine; the slave side is BRAM plus downstream.
interface pooling_average_readout_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_en, rd_addr, out_data, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid,
    output rd_data, out_ready
  );
endinterface

// File: rtl/pooling_average_readout.sv
// Walks the pooling accumulator, scales each sum by a Q0.RECIP_FRAC reciprocal,
// saturates to a byte and streams four channels per 32-bit word.
module pooling_average_readout #(
  parameter int ADDR_W     = 16,
  parameter int RECIP_FRAC = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_ch,
  input  logic [RECIP_FRAC-1:0] recip,
  pooling_average_readout_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam int PROD_W = 32 + RECIP_FRAC;
  localparam logic [PROD_W:0] HALF = {{PROD_W{1'b0}}, 1'b1} << (RECIP_FRAC - 1);

  // S_NOP gives an empty pass one busy cycle so done lands two cycles after start.
  typedef enum logic [2:0] {
    S_IDLE, S_NOP, S_RD, S_WT, S_MUL, S_PK, S_OUT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, num_q, idx_q, last_idx;
  logic [RECIP_FRAC-1:0] recip_q;
  logic [31:0]           sum_q, pack_q;
  logic [PROD_W-1:0]     prod_q, sum_ext, recip_ext;
  logic [PROD_W:0]       rounded, scaled;
  logic [7:0]            avg;
  logic                  start_ok, accept;

  assign start_ok  = (state_q == S_IDLE) && start;
  assign accept    = (state_q == S_OUT) && bus.out_ready;
  assign last_idx  = num_q - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign sum_ext   = {{RECIP_FRAC{1'b0}}, sum_q};
  assign recip_ext = {32'd0, recip_q};
  assign rounded   = {1'b0, prod_q} + HALF;
  assign scaled    = rounded >> RECIP_FRAC;
  assign avg       = (|scaled[PROD_W:8]) ? 8'hFF : scaled[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_ch == '0) ? S_NOP : S_RD;
        end
      end
      S_NOP: state_d = S_DONE;
      S_RD: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base_q + idx_q;
        state_d     = S_WT;
      end
      S_WT:  state_d = S_MUL;
      S_MUL: state_d = S_PK;
      S_PK: begin
        state_d = ((idx_q[1:0] == 2'd3) || (idx_q == last_idx)) ? S_OUT : S_RD;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = pack_q;
        if (bus.out_ready) begin
          state_d = (idx_q == num_q) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers advance only in the state that owns them, so a stalled OUT freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q  <= '0;
      num_q   <= '0;
      recip_q <= '0;
      idx_q   <= '0;
      sum_q   <= 32'd0;
      prod_q  <= '0;
      pack_q  <= 32'd0;
    end else begin
      if (start_ok) begin
        base_q  <= base_addr;
        num_q   <= num_ch;
        recip_q <= recip;
        idx_q   <= '0;
        pack_q  <= 32'd0;
      end
      if (state_q == S_WT) begin
        sum_q <= bus.rd_data;
      end
      if (state_q == S_MUL) begin
        prod_q <= sum_ext * recip_ext;
      end
      if (state_q == S_PK) begin
        pack_q[{idx_q[1:0], 3'b000} +: 8] <= avg;
        idx_q <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (accept) begin
        pack_q <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_pooling_average_readout.sv
// Directed scoreboard bench for pooling_average_readout: expected words and
// addresses are queued by the stimulus thread and popped by a negedge monitor.
module tb_pooling_average_readout;
  localparam int ADDR_W     = 16;
  localparam int RECIP_FRAC = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [ADDR_W-1:0]     num_ch;
  logic [RECIP_FRAC-1:0] recip;
  logic                  busy;
  logic                  done;

  pooling_average_readout_if #(.ADDR_W(ADDR_W)) bus ();

  pooling_average_readout #(.ADDR_W(ADDR_W), .RECIP_FRAC(RECIP_FRAC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .num_ch    (num_ch),
    .recip     (recip),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [15:0]];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data <= mem.exists(bus.rd_addr) ? mem[bus.rd_addr] : 32'd0;
    end
  end

  // rel counts edges since the one that sampled start; the cycle number seen at a negedge is rel+1.
  int rel = 0;
  always @(posedge clk) begin
    if (start && !busy) rel <= 0;
    else                rel <= rel + 1;
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_words [$];
  logic [15:0] exp_addrs [$];
  int          rd_log [$];
  int          valid_log [$];
  int          done_log [$];
  int          hs_cnt = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_data = 32'd0;
  int          r0, v0, d0, h0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rd_en) begin
        rd_log.push_back(rel + 1);
        if (exp_addrs.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rd_extra: got read of 0x%04h want none", bus.rd_addr);
        end else begin
          check_output("rd_addr", 32'(bus.rd_addr), 32'(exp_addrs.pop_front()));
        end
      end
      if (prev_valid && !prev_hs) begin
        check_output("valid_held", 32'(bus.out_valid), 32'd1);
        check_output("data_held", bus.out_data, prev_data);
      end
      if (bus.out_valid && !prev_valid) valid_log.push_back(rel + 1);
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_words.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL word_extra: got 0x%08h want none", bus.out_data);
        end else begin
          check_output("out_word", bus.out_data, exp_words.pop_front());
        end
      end
      if (done) done_log.push_back(rel + 1);
      prev_valid = bus.out_valid;
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  task automatic snap();
    r0 = rd_log.size();
    v0 = valid_log.size();
    d0 = done_log.size();
    h0 = hs_cnt;
  endtask

  task automatic apply_stimulus(input logic [15:0] b, input logic [15:0] n, input logic [15:0] r);
    @(negedge clk);
    base_addr = b;
    num_ch    = n;
    recip     = r;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check_output("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_run(input int n_rd, input int n_hs, input int valid_c, input int done_c);
    check_output("rd_count", 32'(rd_log.size() - r0), 32'(n_rd));
    check_output("hs_count", 32'(hs_cnt - h0), 32'(n_hs));
    check_output("done_count", 32'(done_log.size() - d0), 32'd1);
    if (done_log.size() > d0) check_output("done_cycle", 32'(done_log[d0]), 32'(done_c));
    if (n_hs > 0 && valid_log.size() > v0) check_output("valid_cycle", 32'(valid_log[v0]), 32'(valid_c));
    if (n_hs == 0) check_output("valid_count", 32'(valid_log.size() - v0), 32'd0);
    check_output("words_left", 32'(exp_words.size()), 32'd0);
    check_output("addrs_left", 32'(exp_addrs.size()), 32'd0);
  endtask

  task automatic check_rd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (rd_log.size() > r0 + i) check_output("rd_cycle", 32'(rd_log[r0 + i]), 32'(1 + 4 * i));
    end
  endtask

  // Sums 400, 6, 1022, 40 over a 2x2 window average to 100, 2, 255 (saturated), 10.
  task automatic load_basic(input logic [15:0] b);
    logic [31:0] sums [4] = '{32'd400, 32'd6, 32'd1022, 32'd40};
    for (int i = 0; i < 4; i++) begin
      mem[b + 16'(i)] = sums[i];
      exp_addrs.push_back(b + 16'(i));
    end
    exp_words.push_back(32'h0AFF_0264);
  endtask

  task automatic run_basic();
    load_basic(16'h0010);
    bus.out_ready = 1'b1;
    snap();
    apply_stimulus(16'h0010, 16'd4, 16'd16384);
    wait_done(200);
    check_run(4, 1, 17, 18);
    check_rd_cycles(4);
  endtask

  initial begin
    int  stall_seen;
    int  rd_seen;
    reset_n       = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    num_ch        = '0;
    recip         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_output("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic 2x2 window");
    run_basic();

    $display("[TB] partial final word");
    for (int i = 0; i < 6; i++) begin
      mem[16'h0100 + 16'(i)] = 32'd8;
      exp_addrs.push_back(16'h0100 + 16'(i));
    end
    exp_words.push_back(32'h0202_0202);
    exp_words.push_back(32'h0000_0202);
    snap();
    apply_stimulus(16'h0100, 16'd6, 16'd16384);
    wait_done(200);
    check_run(6, 2, 17, 27);
    check_rd_cycles(4);
    if (rd_log.size() > r0 + 5) begin
      check_output("rd_cycle5", 32'(rd_log[r0 + 4]), 32'd18);
      check_output("rd_cycle6", 32'(rd_log[r0 + 5]), 32'd22);
    end

    $display("[TB] backpressure");
    load_basic(16'h0010);
    bus.out_ready = 1'b0;
    snap();
    apply_stimulus(16'h0010, 16'd4, 16'd16384);
    stall_seen = 0;
    for (int i = 0; i < 100 && stall_seen == 0; i++) begin
      if (bus.out_valid) stall_seen = 1;
      else @(negedge clk);
    end
    check_output("stall_valid_seen", 32'(stall_seen), 32'd1);
    repeat (10) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(200);
    check_run(4, 1, 17, 28);
    check_rd_cycles(4);

    $display("[TB] zero channels");
    snap();
    apply_stimulus(16'h0020, 16'd0, 16'd16384);
    wait_done(20);
    check_run(0, 0, 0, 2);

    $display("[TB] second start ignored");
    load_basic(16'h0010);
    snap();
    apply_stimulus(16'h0010, 16'd4, 16'd16384);
    repeat (4) @(negedge clk);
    base_addr = 16'h0050;
    num_ch    = 16'd0;
    recip     = 16'd1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_done(200);
    check_run(4, 1, 17, 18);
    check_rd_cycles(4);

    $display("[TB] address wrap");
    mem[16'hFFFE] = 32'd4;
    mem[16'hFFFF] = 32'd8;
    mem[16'h0000] = 32'd12;
    mem[16'h0001] = 32'd16;
    exp_addrs.push_back(16'hFFFE);
    exp_addrs.push_back(16'hFFFF);
    exp_addrs.push_back(16'h0000);
    exp_addrs.push_back(16'h0001);
    exp_words.push_back(32'h0403_0201);
    snap();
    apply_stimulus(16'hFFFE, 16'd4, 16'd16384);
    wait_done(200);
    check_run(4, 1, 17, 18);

    $display("[TB] reset mid-pass");
    load_basic(16'h0010);
    snap();
    apply_stimulus(16'h0010, 16'd4, 16'd16384);
    rd_seen = 0;
    for (int i = 0; i < 100 && rd_seen == 0; i++) begin
      if (bus.rd_en && bus.rd_addr == 16'h0012) rd_seen = 1;
      else @(negedge clk);
    end
    check_output("ch2_read_seen", 32'(rd_seen), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_rd_en", 32'(bus.rd_en), 32'd0);
    check_output("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("abort_out_data", bus.out_data, 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    exp_addrs.delete();
    exp_words.delete();
    repeat (2) @(negedge clk);
    check_output("abort_no_done", 32'(done_log.size() - d0), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_basic();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
